// File: rtl/rv_decode_stage.sv
// RV32I decode / operand-fetch stage: decodes one instruction per cycle, presents
// register-file read addresses, and aligns decoded fields with the registered operands.
module rv_decode_stage #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   input  logic [XLEN-1:0] rf_a,
   input  logic [XLEN-1:0] rf_b,
   input  logic            wb_en,
   input  logic [4:0]      wb_reg,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_op_a,
   output logic [XLEN-1:0] out_op_b,
   output logic [XLEN-1:0] out_imm,
   output logic [3:0]      out_alu_op,
   output logic [2:0]      out_funct3,
   output logic            out_use_imm,
   output logic            out_use_pc,
   output logic            out_is_load,
   output logic            out_is_store,
   output logic            out_is_branch,
   output logic            out_is_jump,
   output logic            out_wb_en,
   output logic            out_illegal
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
      logic [3:0] r;
      case (f3)
         3'b000:  r = alt ? ALU_SUB : ALU_ADD;
         3'b001:  r = ALU_SLL;
         3'b010:  r = ALU_SLT;
         3'b011:  r = ALU_SLTU;
         3'b100:  r = ALU_XOR;
         3'b101:  r = alt ? ALU_SRA : ALU_SRL;
         3'b110:  r = ALU_OR;
         default: r = ALU_AND;
      endcase
      return r;
   endfunction

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [4:0] rd_f;

   assign opc  = in_instr[6:0];
   assign f3   = in_instr[14:12];
   assign f7   = in_instr[31:25];
   assign rd_f = in_instr[11:7];

   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign imm_i = {{21{in_instr[31]}}, in_instr[30:20]};
   assign imm_s = {{21{in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
   assign imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u = {in_instr[31:12], 12'b0};
   assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

   logic            d_use_rs1, d_use_rs2, d_writes;
   logic            d_use_imm, d_use_pc, d_load, d_store, d_branch, d_jump, d_ill;
   logic [XLEN-1:0] d_imm;
   logic [3:0]      d_alu;

   // Instruction decode of the incoming word.
   always_comb begin
      d_use_rs1 = 1'b1;
      d_use_rs2 = 1'b0;
      d_writes  = 1'b0;
      d_use_imm = 1'b0;
      d_use_pc  = 1'b0;
      d_load    = 1'b0;
      d_store   = 1'b0;
      d_branch  = 1'b0;
      d_jump    = 1'b0;
      d_ill     = 1'b0;
      d_imm     = '0;
      d_alu     = ALU_ADD;
      case (opc)
         OPC_LUI: begin
            d_use_rs1 = 1'b0;
            d_imm     = imm_u;
            d_alu     = ALU_PASSB;
            d_use_imm = 1'b1;
            d_writes  = 1'b1;
         end
         OPC_AUIPC: begin
            d_use_rs1 = 1'b0;
            d_imm     = imm_u;
            d_use_imm = 1'b1;
            d_use_pc  = 1'b1;
            d_writes  = 1'b1;
         end
         OPC_JAL: begin
            d_use_rs1 = 1'b0;
            d_imm     = imm_j;
            d_use_imm = 1'b1;
            d_use_pc  = 1'b1;
            d_jump    = 1'b1;
            d_writes  = 1'b1;
         end
         OPC_JALR: begin
            d_imm     = imm_i;
            d_use_imm = 1'b1;
            d_jump    = 1'b1;
            d_writes  = 1'b1;
            d_ill     = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            d_use_rs2 = 1'b1;
            d_imm     = imm_b;
            d_branch  = 1'b1;
            case (f3[2:1])
               2'b00:   d_alu = ALU_SUB;
               2'b10:   d_alu = ALU_SLT;
               2'b11:   d_alu = ALU_SLTU;
               default: d_ill = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            d_imm     = imm_i;
            d_use_imm = 1'b1;
            d_load    = 1'b1;
            d_writes  = 1'b1;
            d_ill     = (f3 == 3'b011) || (f3[2:1] == 2'b11);
         end
         OPC_STORE: begin
            d_use_rs2 = 1'b1;
            d_imm     = imm_s;
            d_use_imm = 1'b1;
            d_store   = 1'b1;
            d_ill     = (f3 > 3'b010);
         end
         OPC_OPIMM: begin
            d_imm     = imm_i;
            d_use_imm = 1'b1;
            d_writes  = 1'b1;
            d_alu     = alu_of(f3, (f3 == 3'b101) && f7[5]);
            if (f3 == 3'b001)
               d_ill = (f7 != F7_BASE);
            else if (f3 == 3'b101)
               d_ill = (f7 != F7_BASE) && (f7 != F7_ALT);
         end
         OPC_OP: begin
            d_use_rs2 = 1'b1;
            d_writes  = 1'b1;
            d_alu     = alu_of(f3, f7[5]);
            d_ill     = !((f7 == F7_BASE) ||
                          ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
         end
         default: d_ill = 1'b1;
      endcase
   end

   logic [4:0] rs1_dec, rs2_dec;
   logic [4:0] rs1_q, rs2_q;
   logic       accept;

   assign rs1_dec  = d_use_rs1 ? in_instr[19:15] : 5'd0;
   assign rs2_dec  = d_use_rs2 ? in_instr[24:20] : 5'd0;
   assign in_ready = !flush && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Addresses idle at x0 during reset so operands read back as zero afterwards.
   assign rs1 = reset ? 5'd0 : (accept ? rs1_dec : rs1_q);
   assign rs2 = reset ? 5'd0 : (accept ? rs2_dec : rs2_q);

   logic            byp_a_v_q, byp_b_v_q;
   logic [XLEN-1:0] byp_a_d_q, byp_b_d_q;

   assign out_op_a = byp_a_v_q ? byp_a_d_q : rf_a;
   assign out_op_b = byp_b_v_q ? byp_b_d_q : rf_b;

   // Pipeline register and writeback bypass capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid     <= 1'b0;
         out_pc        <= '0;
         out_rd        <= '0;
         out_imm       <= '0;
         out_alu_op    <= '0;
         out_funct3    <= '0;
         out_use_imm   <= 1'b0;
         out_use_pc    <= 1'b0;
         out_is_load   <= 1'b0;
         out_is_store  <= 1'b0;
         out_is_branch <= 1'b0;
         out_is_jump   <= 1'b0;
         out_wb_en     <= 1'b0;
         out_illegal   <= 1'b0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         byp_a_v_q     <= 1'b0;
         byp_b_v_q     <= 1'b0;
         byp_a_d_q     <= '0;
         byp_b_d_q     <= '0;
      end else begin
         byp_a_v_q <= wb_en && (wb_reg != 5'd0) && (wb_reg == rs1);
         byp_b_v_q <= wb_en && (wb_reg != 5'd0) && (wb_reg == rs2);
         byp_a_d_q <= wb_data;
         byp_b_d_q <= wb_data;
         if (flush) begin
            out_valid <= 1'b0;
         end else if (accept) begin
            out_valid     <= 1'b1;
            out_pc        <= in_pc;
            out_rd        <= rd_f;
            out_imm       <= d_imm;
            out_alu_op    <= d_alu;
            out_funct3    <= f3;
            out_use_imm   <= d_use_imm;
            out_use_pc    <= d_use_pc;
            out_is_load   <= d_load && !d_ill;
            out_is_store  <= d_store && !d_ill;
            out_is_branch <= d_branch && !d_ill;
            out_is_jump   <= d_jump && !d_ill;
            out_wb_en     <= d_writes && (rd_f != 5'd0) && !d_ill;
            out_illegal   <= d_ill;
            rs1_q         <= rs1_dec;
            rs2_q         <= rs2_dec;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: directed scenarios plus a randomized run, checked against
// an architectural register file and an instruction-level decode model.
module tb_rv_decode_stage;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, wb_en, flush, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, rf_a, rf_b, wb_data;
   logic [4:0]  rs1, rs2, wb_reg, out_rd;
   logic [31:0] out_pc, out_op_a, out_op_b, out_imm;
   logic [3:0]  out_alu_op;
   logic [2:0]  out_funct3;
   logic        out_use_imm, out_use_pc, out_is_load, out_is_store;
   logic        out_is_branch, out_is_jump, out_wb_en, out_illegal;

   always #5 clk = ~clk;

   rv_decode_stage #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .rs1(rs1), .rs2(rs2), .rf_a(rf_a), .rf_b(rf_b),
      .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
      .out_op_a(out_op_a), .out_op_b(out_op_b), .out_imm(out_imm), .out_alu_op(out_alu_op),
      .out_funct3(out_funct3), .out_use_imm(out_use_imm), .out_use_pc(out_use_pc),
      .out_is_load(out_is_load), .out_is_store(out_is_store), .out_is_branch(out_is_branch),
      .out_is_jump(out_is_jump), .out_wb_en(out_wb_en), .out_illegal(out_illegal)
   );

   // Register file: registered reads, writes land at the edge (reads see old data).
   logic [31:0] regs [32];
   always @(posedge clk) begin
      rf_a <= regs[rs1];
      rf_b <= regs[rs2];
      if (wb_en && wb_reg != 5'd0) regs[wb_reg] <= wb_data;
   end

   typedef struct packed {
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic        use_imm, use_pc, ld, st, br, jp, wb, ill;
   } ref_t;

   typedef logic [147:0] vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   logic        m_valid;
   logic [31:0] m_instr, m_pc;

   function automatic ref_t ref_dec(input logic [31:0] w);
      ref_t r;
      int   op, f3, f7, v;
      int   alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
      logic writes;
      r = '0;
      writes = 1'b0;
      op = int'(w[6:0]);
      f3 = int'(w[14:12]);
      f7 = int'(w[31:25]);
      r.rd = w[11:7];
      r.rs1 = (op == 'h37 || op == 'h17 || op == 'h6F) ? 5'd0 : w[19:15];
      r.rs2 = (op == 'h33 || op == 'h23 || op == 'h63) ? w[24:20] : 5'd0;
      case (op)
         'h37, 'h17: begin
            r.imm = (w >> 12) << 12;
            r.alu = (op == 'h37) ? 4'd10 : 4'd0;
            r.use_imm = 1'b1; r.use_pc = (op == 'h17); writes = 1'b1;
         end
         'h6F: begin
            v = int'(w[31]) * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            if (v >= (1 << 20)) v -= (1 << 21);
            r.imm = 32'(v); r.use_imm = 1'b1; r.use_pc = 1'b1; r.jp = 1'b1; writes = 1'b1;
         end
         'h63: begin
            v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            if (v >= 4096) v -= 8192;
            r.imm = 32'(v); r.br = 1'b1;
            r.alu = (f3 < 2) ? 4'd1 : (f3 < 6) ? 4'd3 : 4'd4;
            r.ill = (f3 == 2 || f3 == 3);
         end
         'h23: begin
            v = f7 * 32 + int'(w[11:7]);
            if (v >= 2048) v -= 4096;
            r.imm = 32'(v); r.use_imm = 1'b1; r.st = 1'b1; r.ill = (f3 > 2);
         end
         'h67, 'h03, 'h13: begin
            v = int'(w[31:20]);
            if (v >= 2048) v -= 4096;
            r.imm = 32'(v); r.use_imm = 1'b1; writes = 1'b1;
            if (op == 'h67) begin r.jp = 1'b1; r.ill = (f3 != 0); end
            if (op == 'h03) begin r.ld = 1'b1; r.ill = (f3 == 3 || f3 >= 6); end
            if (op == 'h13) begin
               r.alu = 4'(alu_tab[f3]);
               if (f3 == 5 && f7 == 32) r.alu = 4'd7;
               if (f3 == 1) r.ill = (f7 != 0);
               if (f3 == 5) r.ill = !(f7 == 0 || f7 == 32);
            end
         end
         'h33: begin
            writes = 1'b1;
            r.alu = 4'(alu_tab[f3]);
            if (f7 == 32 && f3 == 0) r.alu = 4'd1;
            if (f7 == 32 && f3 == 5) r.alu = 4'd7;
            r.ill = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
         end
         default: r.ill = 1'b1;
      endcase
      if (r.ill) begin r.ld = 0; r.st = 0; r.br = 0; r.jp = 0; end
      r.wb = writes && (r.rd != 5'd0) && !r.ill;
      return r;
   endfunction

   function automatic vec_t obs_vec();
      return {out_pc, out_rd, out_op_a, out_op_b, out_imm, out_alu_op, out_funct3,
              out_use_imm, out_use_pc, out_is_load, out_is_store, out_is_branch,
              out_is_jump, out_wb_en, out_illegal};
   endfunction

   function automatic vec_t exp_vec();
      ref_t r;
      r = ref_dec(m_instr);
      return {m_pc, r.rd, regs[r.rs1], regs[r.rs2], r.imm, r.alu, m_instr[14:12],
              r.use_imm, r.use_pc, r.ld, r.st, r.br, r.jp, r.wb, r.ill};
   endfunction

   // Field selection is left open for illegal encodings.
   function automatic vec_t mask_vec();
      logic i;
      i = ref_dec(m_instr).ill;
      return {32'hFFFFFFFF, 5'h1F, 64'hFFFFFFFF_FFFFFFFF, i ? 32'h0 : 32'hFFFFFFFF,
              i ? 4'h0 : 4'hF, 3'h7, i ? 2'b00 : 2'b11, 6'h3F};
   endfunction

   function automatic logic [9:0] exp_rs();
      ref_t r;
      logic acc;
      acc = in_valid && !flush && (!m_valid || out_ready);
      r = acc ? ref_dec(in_instr) : ref_dec(m_instr);
      return {r.rs1, r.rs2};
   endfunction

   // Advance one clock, keeping the stage model in step.
   task automatic cycle();
      logic acc;
      acc = in_valid && !flush && (!m_valid || out_ready);
      @(posedge clk);
      if (reset) begin
         m_valid = 1'b0; m_instr = '0; m_pc = '0;
      end else if (flush) m_valid = 1'b0;
      else if (acc) begin
         m_valid = 1'b1; m_instr = in_instr; m_pc = in_pc;
      end else if (out_ready) m_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cycle(); cycle();
      reset = 1'b0; out_ready = 1'b1;
      #1;
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_bad++; $display("FAIL reset_hs: valid/in_ready got %b want 01", {out_valid, in_ready});
      end
      n_cmp++;
      if (obs_vec() !== '0) begin
         n_bad++; $display("FAIL reset_out: got %h want 0", obs_vec());
      end
   endtask

   task automatic test_addi();
      in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100; out_ready = 1'b1;
      #1;
      n_cmp++;
      if ({in_ready, rs1, rs2} !== {1'b1, 5'd0, 5'd0}) begin
         n_bad++; $display("FAIL addi_rs: got %b want 1_00000_00000", {in_ready, rs1, rs2});
      end
      cycle();
      in_valid = 1'b0;
      n_cmp++;
      if ({out_valid, out_rd, out_imm, out_alu_op, out_use_imm, out_wb_en, out_op_a} !==
          {1'b1, 5'd1, 32'd5, 4'd0, 1'b1, 1'b1, 32'd0}) begin
         n_bad++; $display("FAIL addi_fields: valid=%b rd=%0d imm=%h alu=%0d ui=%b wb=%b opa=%h",
                           out_valid, out_rd, out_imm, out_alu_op, out_use_imm, out_wb_en, out_op_a);
      end
      n_cmp++;
      if ((obs_vec() & mask_vec()) !== (exp_vec() & mask_vec())) begin
         n_bad++; $display("FAIL addi_model: got %h want %h", obs_vec(), exp_vec());
      end
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++; $display("FAIL addi_ready: got %b want 1", in_ready);
      end
      cycle();
   endtask

   task automatic test_bypass();
      in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h200; out_ready = 1'b1;
      wb_en = 1'b1; wb_reg = 5'd1; wb_data = 32'hDEADBEEF;
      cycle();
      in_valid = 1'b0; wb_en = 1'b0;
      n_cmp++;
      if ({out_valid, out_op_a, out_alu_op} !== {1'b1, 32'hDEADBEEF, 4'd0}) begin
         n_bad++; $display("FAIL bypass_a: valid=%b op_a=%h alu=%0d want 1 deadbeef 0",
                           out_valid, out_op_a, out_alu_op);
      end
      cycle();
      in_valid = 1'b1; wb_en = 1'b1; wb_reg = 5'd0; wb_data = 32'h12345678;
      cycle();
      in_valid = 1'b0; wb_en = 1'b0;
      n_cmp++;
      if (out_op_a !== 32'hDEADBEEF || (obs_vec() !== exp_vec())) begin
         n_bad++; $display("FAIL bypass_x0: op_a=%h want deadbeef; got %h want %h",
                           out_op_a, obs_vec(), exp_vec());
      end
      cycle();
   endtask

   task automatic test_back_to_back_stall();
      in_valid = 1'b1; in_instr = 32'h402081B3; in_pc = 32'h300; out_ready = 1'b1;
      cycle();
      in_instr = 32'h00500093; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin wb_en = 1'b1; wb_reg = 5'd2; wb_data = 32'd7; end
         else wb_en = 1'b0;
         #1;
         n_cmp++;
         if ({in_ready, rs1, rs2} !== {1'b0, 5'd1, 5'd2}) begin
            n_bad++; $display("FAIL stall_rs[%0d]: got %b want 0_00001_00010", i, {in_ready, rs1, rs2});
         end
         cycle();
         n_cmp++;
         if (!out_valid || out_alu_op !== 4'd1 || out_pc !== 32'h300 || obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL stall_hold[%0d]: valid=%b got %h want %h", i, out_valid, obs_vec(), exp_vec());
         end
         if (i >= 1) begin
            n_cmp++;
            if (out_op_b !== 32'd7) begin
               n_bad++; $display("FAIL stall_byp_b[%0d]: got %h want 7", i, out_op_b);
            end
         end
      end
      wb_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      cycle();
   endtask

   task automatic test_lui_branch();
      in_valid = 1'b1; in_instr = 32'h123452B7; out_ready = 1'b1;
      #1;
      n_cmp++;
      if ({rs1, rs2} !== 10'd0) begin
         n_bad++; $display("FAIL lui_rs: got %b want 0", {rs1, rs2});
      end
      cycle();
      n_cmp++;
      if ({out_imm, out_alu_op, out_rd, out_wb_en} !== {32'h12345000, 4'd10, 5'd5, 1'b1}) begin
         n_bad++; $display("FAIL lui: imm=%h alu=%0d rd=%0d wb=%b", out_imm, out_alu_op, out_rd, out_wb_en);
      end
      in_instr = 32'hFE000EE3;
      cycle();
      in_valid = 1'b0;
      n_cmp++;
      if ({out_imm, out_is_branch, out_wb_en, out_alu_op, out_use_imm} !==
          {32'hFFFFFFFC, 1'b1, 1'b0, 4'd1, 1'b0}) begin
         n_bad++; $display("FAIL beq: imm=%h br=%b wb=%b alu=%0d ui=%b",
                           out_imm, out_is_branch, out_wb_en, out_alu_op, out_use_imm);
      end
      cycle();
   endtask

   task automatic test_illegal();
      logic [31:0] words [2];
      words[0] = 32'hFFFFFFFF;
      words[1] = 32'h4020C0B3;
      foreach (words[k]) begin
         in_valid = 1'b1; in_instr = words[k]; out_ready = 1'b1;
         cycle();
         in_valid = 1'b0;
         n_cmp++;
         if ({out_valid, out_illegal, out_wb_en, out_is_load, out_is_store, out_is_branch, out_is_jump} !==
             7'b1100000) begin
            n_bad++; $display("FAIL illegal[%0d]: v/ill/wb/ld/st/br/jp got %b want 1100000", k,
               {out_valid, out_illegal, out_wb_en, out_is_load, out_is_store, out_is_branch, out_is_jump});
         end
      end
      cycle();
   endtask

   task automatic test_flush_and_reset();
      in_valid = 1'b1; in_instr = 32'h00500093; out_ready = 1'b0;
      cycle();
      flush = 1'b1; in_instr = 32'h123452B7;
      #1;
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b10) begin
         n_bad++; $display("FAIL flush_ready: valid/in_ready got %b want 10", {out_valid, in_ready});
      end
      cycle();
      flush = 1'b0; in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++; $display("FAIL flush_kill: valid got %b want 0", out_valid);
      end
      cycle();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++; $display("FAIL flush_noacc: valid got %b want 0", out_valid);
      end
      in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h440;
      cycle(); cycle();
      n_cmp++;
      if (out_valid !== 1'b1 || out_op_a !== 32'hDEADBEEF) begin
         n_bad++; $display("FAIL pre_reset: valid=%b op_a=%h want 1 deadbeef", out_valid, out_op_a);
      end
      reset = 1'b1;
      cycle();
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b01 || obs_vec() !== '0) begin
         n_bad++; $display("FAIL reset_stall: valid=%b ready=%b out=%h want 0 1 0", out_valid, in_ready, obs_vec());
      end
      cycle();
   endtask

   task automatic test_random();
      logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
      logic [31:0] w;
      int k;
      for (int i = 0; i < 400; i++) begin
         w = $urandom;
         k = $urandom_range(0, 9);
         if (k < 9) begin
            w[6:0] = ops[k];
            if ((k >= 7) && ($urandom_range(0, 3) != 0)) w[31:25] = w[0] ? 7'h20 : 7'h00;
         end
         in_instr  = w;
         in_pc     = $urandom & 32'hFFFF_FFFC;
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 19) == 0);
         wb_en     = $urandom_range(0, 1) == 1;
         wb_reg    = 5'($urandom_range(0, 7));
         wb_data   = $urandom;
         #1;
         n_cmp++;
         if ({in_ready, rs1, rs2} !== {!flush && (!m_valid || out_ready), exp_rs()}) begin
            n_bad++; $display("FAIL rnd_req[%0d]: got %b want %b", i, {in_ready, rs1, rs2},
                              {!flush && (!m_valid || out_ready), exp_rs()});
         end
         cycle();
         n_cmp++;
         if (out_valid !== m_valid) begin
            n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, m_valid);
         end
         if (m_valid) begin
            n_cmp++;
            if ((obs_vec() & mask_vec()) !== (exp_vec() & mask_vec())) begin
               n_bad++; $display("FAIL rnd_out[%0d] instr=%h: got %h want %h", i, m_instr,
                                 obs_vec() & mask_vec(), exp_vec() & mask_vec());
            end
         end
      end
      in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0;
   endtask

   initial begin
      for (int r = 0; r < 32; r++) regs[r] = '0;
      rf_a = '0; rf_b = '0;
      reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
      wb_en = 1'b0; wb_reg = '0; wb_data = '0; flush = 1'b0;
      m_valid = 1'b0; m_instr = '0; m_pc = '0;
      test_reset();
      test_addi();
      test_bypass();
      test_back_to_back_stall();
      test_lui_branch();
      test_illegal();
      test_flush_and_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Decode/operand-fetch stage of the RV32I pipeline.
- Accepts one instruction per cycle from fetch and decodes it.
- Drives the register file read addresses combinationally. The register file returns operands registered, one cycle later.
- Aligns decoded control fields with those operands in a single-entry pipeline register, with valid/ready handshakes on both sides.
- Adds a writeback bypass, because a register-file write and a read of the same register on the same edge return the old value.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch has an instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  32  instruction PC
- rs1  out  5  register file read address A
- rs2  out  5  register file read address B
- rf_a  in  32  register file port A data (registered, 1-cycle latency)
- rf_b  in  32  register file port B data
- wb_en  in  1  writeback enable (same signal as register file write_en)
- wb_reg  in  5  writeback register index
- wb_data  in  32  writeback data
- flush  in  1  kill held and incoming instruction
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  execute accepts
- out_pc  out  32  PC
- out_rd  out  5  destination register
- out_op_a  out  32  rs1 value, bypassed
- out_op_b  out  32  rs2 value, bypassed
- out_imm  out  32  sign-extended immediate
- out_alu_op  out  4  ALU function code
- out_funct3  out  3  raw funct3
- out_use_imm  out  1  ALU B operand is imm
- out_use_pc  out  1  ALU A operand is pc
- out_is_load  out  1  load instruction
- out_is_store  out  1  store instruction
- out_is_branch  out  1  branch instruction
- out_is_jump  out  1  JAL/JALR
- out_wb_en  out  1  writes rd (0 when rd==0)
- out_illegal  out  1  unsupported encoding

Behaviour:
- **Reset:** all out_* registers are 0 and out_valid=0. Bypass flags are cleared. in_ready=1 after reset.
- **Handshake:**
  - in_ready = !flush && (!out_valid || out_ready).
  - Accept = in_valid && in_ready. On accept, all out_* fields are loaded and out_valid=1 at the next edge.
  - If out_ready && !accept, out_valid clears.
  - Otherwise all outputs hold stable.
- **Flush:** synchronous; out_valid <= 0 at the edge. An incoming instruction is not accepted. Flush has priority over accept and hold.
- **Read address presentation (combinational):**
  - On accept, rs1 = in_instr[19:15] and rs2 = in_instr[24:20].
  - Otherwise rs1/rs2 = the held instruction's source fields, so the register file re-reads every cycle while stalled.
  - Source fields are forced to 0 when unused: rs1 for LUI/AUIPC/JAL; rs2 for anything except R/S/B types.
- **Bypass, per operand, every edge:**
  - byp_a_v <= wb_en && wb_reg!=0 && wb_reg==rs1; byp_a_d <= wb_data. Port B uses rs2 identically.
  - out_op_a = byp_a_v ? byp_a_d : rf_a; out_op_b uses the same rule.
  - This is correct in the accept cycle and on every stall cycle.
- **Immediates:** I, S, B, U and J formats, sign-extended from instr[31]. B and J have bit 0 = 0. U is instr[31:12]<<12. R-type imm = 0.
- **out_alu_op encoding:**
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
  - Loads, stores, AUIPC, JAL and JALR use ADD. LUI uses PASSB.
  - Branches take ALU code from compare type: BEQ/BNE SUB, BLT/BGE SLT, BLTU/BGEU SLTU.
- **Operand selects:**
  - use_pc = 1 for AUIPC and JAL.
  - use_imm = 1 for all types except R and B.
- **Illegal encodings:**
  - Any opcode outside {LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011}.
  - funct3 010/011 on BRANCH.
  - LOAD funct3 011/110/111; STORE funct3 >010.
  - JALR funct3!=0.
  - OP funct7 other than 0000000, or 0100000 with funct3 000/101.
  - OP-IMM shifts with a bad funct7.
  - Result: out_illegal=1 and wb_en, is_load, is_store, is_branch, is_jump are all 0; out_valid is still asserted.
- **Write enable:** out_wb_en = writes-rd type && rd!=0.
- **Reset mid-stall:** the held instruction is discarded and out_valid=0.

Test Plan:
- Reset, then in 0x00500093 (ADDI x1,x0,5), out_ready=1 -> next cycle out_valid=1, rd=1, imm=5, alu_op=0, use_imm=1, wb_en=1, op_a=0; in_ready stays 1.
- Writeback x1=0xDEADBEEF on the accept edge of 0x002081B3 (ADD x3,x1,x2), with rf_a returning old 0 -> out_op_a=0xDEADBEEF, alu_op=0; repeat with wb_reg=0 -> out_op_a=rf_a.
- Hold out_ready=0 for 3 cycles after accepting 0x402081B3 (SUB) -> in_ready=0; outputs stable; rs1=1, rs2=2 held; alu_op=1. A write x2=7 during the stall appears on op_b next cycle.
- 0x123452B7 (LUI x5) -> rs1=0, rs2=0, imm=0x12345000, alu_op=10. 0xFE000EE3 (BEQ x0,x0,-4) -> imm=0xFFFFFFFC, is_branch=1, wb_en=0, alu_op=1.
- 0xFFFFFFFF and 0x0020C0B3 with funct7=0x20 (invalid XOR) -> out_illegal=1, wb_en=0, out_valid=1.
- flush while holding a valid instruction with in_valid=1 -> next cycle out_valid=0, nothing accepted; reset asserted mid-stall -> out_valid=0 and all outputs 0.
